// File: rtl/watch_mode_sequencer_if.sv
// Button, live-source and display/commit signals of watch_mode_sequencer.
// master = the surrounding watch controller, slave = the sequencer itself.
interface watch_mode_sequencer_if #(
    parameter int NUM_MODES   = 4,
    parameter int NUM_DIGITS  = 7,
    parameter int EDIT_DIGITS = 4
);
    localparam int MW = (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1;

    logic                              mode_next;
    logic                              set_btn;
    logic                              next_digit;
    logic                              up_btn;
    logic [NUM_MODES*NUM_DIGITS*4-1:0] src_data;
    logic [NUM_MODES-1:0]              src_char;

    logic [MW-1:0]                     mode;
    logic                              editing;
    logic [NUM_DIGITS*4-1:0]           disp_data;
    logic                              disp_char;
    logic [NUM_DIGITS-1:0]             disp_blank;
    logic                              commit_valid;
    logic [MW-1:0]                     commit_mode;
    logic [EDIT_DIGITS*4-1:0]          commit_data;

    modport master (
        output mode_next, set_btn, next_digit, up_btn, src_data, src_char,
        input  mode, editing, disp_data, disp_char, disp_blank,
               commit_valid, commit_mode, commit_data
    );

    modport slave (
        input  mode_next, set_btn, next_digit, up_btn, src_data, src_char,
        output mode, editing, disp_data, disp_char, disp_blank,
               commit_valid, commit_mode, commit_data
    );
endinterface

// File: rtl/watch_mode_sequencer.sv
// Mode/display sequencer with a cursor-based digit edit session and one-cycle commit strobe.
// Optional cursor blink is enabled by defining WATCHCTRL_BLINK_EN.
module watch_mode_sequencer #(
    parameter int                   NUM_MODES   = 4,
    parameter int                   NUM_DIGITS  = 7,
    parameter int                   EDIT_DIGITS = 4,
    parameter logic [NUM_MODES-1:0] EDIT_MASK   = 4'b1101,
    parameter int                   BLINK_DIV   = 4
) (
    input logic                   clk,
    input logic                   reset,
    watch_mode_sequencer_if.slave bus
);
    localparam int MW = (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1;
    localparam int CW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int LO = NUM_DIGITS - EDIT_DIGITS;
    localparam int DW = NUM_DIGITS * 4;
    localparam int EW = EDIT_DIGITS * 4;
    localparam logic [CW-1:0] CUR_TOP = CW'(NUM_DIGITS - 1);
    localparam logic [CW-1:0] CUR_LOW = CW'(LO);
    localparam logic [MW-1:0] MODE_LAST = MW'(NUM_MODES - 1);

    typedef enum logic [1:0] {
        VIEW   = 2'd0,
        EDIT   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t                state;
    logic [MW-1:0]         mode_q;
    logic [CW-1:0]         cursor;
    logic [EW-1:0]         edit_buf;
    logic                  editing_q;
    logic [DW-1:0]         disp_data_q;
    logic                  disp_char_q;
    logic                  commit_valid_q;
    logic [MW-1:0]         commit_mode_q;
    logic [EW-1:0]         commit_data_q;
    logic [NUM_DIGITS-1:0] disp_blank_d;

    logic [DW-1:0]         live_digits;
    logic                  live_char;
    logic                  live_editable;
    logic [EW-1:0]         edit_buf_inc;
    logic [DW-1:0]         edit_view;
    logic [CW-1:0]         cursor_left;
    logic                  enter_edit;

    function automatic logic [3:0] bump_digit(input logic [3:0] d, input logic char_mode);
        if (char_mode) begin
            return d + 4'd1;
        end
        return (d >= 4'd9) ? 4'd0 : d + 4'd1;
    endfunction

    // Everything the current mode selects: its live digits, char flag and editability.
    always_comb begin
        live_digits   = '0;
        live_char     = 1'b0;
        live_editable = 1'b0;
        for (int m = 0; m < NUM_MODES; m++) begin
            if (mode_q == MW'(m)) begin
                live_digits   = bus.src_data[m*DW +: DW];
                live_char     = bus.src_char[m];
                live_editable = EDIT_MASK[m];
            end
        end
    end

    always_comb begin
        edit_buf_inc = edit_buf;
        for (int k = 0; k < EDIT_DIGITS; k++) begin
            if (cursor == CW'(LO + k)) begin
                edit_buf_inc[k*4 +: 4] = bump_digit(edit_buf[k*4 +: 4], live_char);
            end
        end
        edit_view              = '0;
        edit_view[DW-1 -: EW]  = edit_buf;
    end

    assign cursor_left = (cursor == CUR_LOW) ? CUR_TOP : cursor - CW'(1);
    assign enter_edit  = (state == VIEW) && bus.set_btn && live_editable;

    // Display and commit registers follow the state held before the edge, which gives
    // the one-cycle lag between a state change and the data that goes with it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= VIEW;
            mode_q         <= '0;
            cursor         <= CUR_TOP;
            edit_buf       <= '0;
            editing_q      <= 1'b0;
            disp_data_q    <= '0;
            disp_char_q    <= 1'b0;
            commit_valid_q <= 1'b0;
            commit_mode_q  <= '0;
            commit_data_q  <= '0;
        end else begin
            disp_char_q    <= live_char;
            disp_data_q    <= (state == VIEW) ? live_digits : edit_view;
            commit_valid_q <= (state == COMMIT);
            if (state == COMMIT) begin
                commit_mode_q <= mode_q;
                commit_data_q <= edit_buf;
            end

            case (state)
                VIEW: begin
                    if (enter_edit) begin
                        state     <= EDIT;
                        editing_q <= 1'b1;
                        edit_buf  <= live_digits[DW-1 -: EW];
                        cursor    <= CUR_TOP;
                    end else if (bus.mode_next) begin
                        mode_q <= (mode_q == MODE_LAST) ? '0 : mode_q + MW'(1);
                    end
                end
                EDIT: begin
                    if (bus.set_btn) begin
                        state     <= COMMIT;
                        editing_q <= 1'b0;
                    end else if (bus.mode_next) begin
                        state     <= VIEW;
                        editing_q <= 1'b0;
                    end else begin
                        if (bus.up_btn) begin
                            edit_buf <= edit_buf_inc;
                        end
                        if (bus.next_digit) begin
                            cursor <= cursor_left;
                        end
                    end
                end
                COMMIT: begin
                    state <= VIEW;
                end
                default: begin
                    state     <= VIEW;
                    editing_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef WATCHCTRL_BLINK_EN
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    logic [BW-1:0] blink_cnt;
    logic          blink_on;

    // Each session starts with the cursor visible; the phase flips every BLINK_DIV cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blink_cnt <= '0;
            blink_on  <= 1'b1;
        end else if (enter_edit) begin
            blink_cnt <= '0;
            blink_on  <= 1'b1;
        end else if (state == EDIT) begin
            if (blink_cnt == BLINK_LAST) begin
                blink_cnt <= '0;
                blink_on  <= ~blink_on;
            end else begin
                blink_cnt <= blink_cnt + BW'(1);
            end
        end
    end

    always_comb begin
        disp_blank_d = '0;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            if (editing_q && !blink_on && (cursor == CW'(d))) begin
                disp_blank_d[d] = 1'b1;
            end
        end
    end
`else
    assign disp_blank_d = '0;
`endif

    assign bus.mode         = mode_q;
    assign bus.editing      = editing_q;
    assign bus.disp_data    = disp_data_q;
    assign bus.disp_char    = disp_char_q;
    assign bus.disp_blank   = disp_blank_d;
    assign bus.commit_valid = commit_valid_q;
    assign bus.commit_mode  = commit_mode_q;
    assign bus.commit_data  = commit_data_q;
endmodule

// File: tb/tb_watch_mode_sequencer.sv
// Self-checking bench for watch_mode_sequencer: directed steps then random button traffic,
// every cycle compared against a digit-level model of the mode/edit behaviour.
module tb_watch_mode_sequencer;
    localparam int NUM_MODES   = 4;
    localparam int NUM_DIGITS  = 7;
    localparam int EDIT_DIGITS = 4;
    localparam int BLINK_DIV   = 4;
    localparam logic [NUM_MODES-1:0] EDIT_MASK = 4'b1101;
    localparam int MW = 2;
    localparam int DW = NUM_DIGITS * 4;
    localparam int EW = EDIT_DIGITS * 4;
    localparam int LO = NUM_DIGITS - EDIT_DIGITS;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    logic                              mode_next;
    logic                              set_btn;
    logic                              next_digit;
    logic                              up_btn;
    logic [NUM_MODES*NUM_DIGITS*4-1:0] src_data;
    logic [NUM_MODES-1:0]              src_char;

    watch_mode_sequencer_if #(
        .NUM_MODES(NUM_MODES), .NUM_DIGITS(NUM_DIGITS), .EDIT_DIGITS(EDIT_DIGITS)
    ) bus ();

    assign bus.mode_next  = mode_next;
    assign bus.set_btn    = set_btn;
    assign bus.next_digit = next_digit;
    assign bus.up_btn     = up_btn;
    assign bus.src_data   = src_data;
    assign bus.src_char   = src_char;

    watch_mode_sequencer #(
        .NUM_MODES(NUM_MODES), .NUM_DIGITS(NUM_DIGITS), .EDIT_DIGITS(EDIT_DIGITS),
        .EDIT_MASK(EDIT_MASK), .BLINK_DIV(BLINK_DIV)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int checks  = 0;
    int errors  = 0;
    int commits = 0;

    // Reference model: a digit array per edit session plus flags for "editing" and "commit due".
    int             m_mode;
    bit             m_edit;
    bit             m_commit;
    int             m_cursor;
    int             m_buf[NUM_DIGITS];
    int             m_edit_cycles;
    logic [DW-1:0]  e_disp;
    logic           e_char;
    logic           e_valid;
    logic [MW-1:0]  e_cmode;
    logic [EW-1:0]  e_cdata;

    function automatic int live_digit(input int m, input int d);
        return int'(src_data[(m*NUM_DIGITS + d)*4 +: 4]);
    endfunction

    function automatic logic [DW-1:0] live_slice(input int m);
        logic [DW-1:0] v;
        v = '0;
        for (int d = 0; d < NUM_DIGITS; d++) v[d*4 +: 4] = 4'(live_digit(m, d));
        return v;
    endfunction

    function automatic logic [DW-1:0] model_view();
        logic [DW-1:0] v;
        v = '0;
        for (int d = LO; d < NUM_DIGITS; d++) v[d*4 +: 4] = 4'(m_buf[d]);
        return v;
    endfunction

    function automatic logic [EW-1:0] model_pack();
        logic [EW-1:0] v;
        v = '0;
        for (int k = 0; k < EDIT_DIGITS; k++) v[k*4 +: 4] = 4'(m_buf[LO + k]);
        return v;
    endfunction

    function automatic int bump(input int v, input bit char_mode);
        if (char_mode) return (v + 1) % 16;
        return (v >= 9) ? 0 : v + 1;
    endfunction

    function automatic logic [NUM_DIGITS-1:0] model_blank();
        logic [NUM_DIGITS-1:0] b;
        b = '0;
`ifdef WATCHCTRL_BLINK_EN
        if (m_edit && (((m_edit_cycles / BLINK_DIV) % 2) == 1)) b[m_cursor] = 1'b1;
`endif
        return b;
    endfunction

    task automatic model_reset();
        m_mode        = 0;
        m_edit        = 0;
        m_commit      = 0;
        m_cursor      = NUM_DIGITS - 1;
        m_edit_cycles = 0;
        for (int d = 0; d < NUM_DIGITS; d++) m_buf[d] = 0;
        e_disp  = '0;
        e_char  = 1'b0;
        e_valid = 1'b0;
        e_cmode = '0;
        e_cdata = '0;
    endtask

    // Advance the model by one clock using the buttons/sources presented before the edge.
    task automatic model_edge();
        e_char  = src_char[m_mode];
        e_valid = m_commit;
        if (m_commit) begin
            e_cmode = MW'(m_mode);
            e_cdata = model_pack();
        end
        e_disp = (m_edit || m_commit) ? model_view() : live_slice(m_mode);

        if (m_commit) begin
            m_commit = 0;
        end else if (m_edit) begin
            if (set_btn) begin
                m_edit   = 0;
                m_commit = 1;
            end else if (mode_next) begin
                m_edit = 0;
            end else begin
                if (up_btn) m_buf[m_cursor] = bump(m_buf[m_cursor], src_char[m_mode]);
                if (next_digit) m_cursor = (m_cursor == LO) ? NUM_DIGITS - 1 : m_cursor - 1;
                m_edit_cycles++;
            end
        end else begin
            if (set_btn && EDIT_MASK[m_mode]) begin
                for (int d = 0; d < NUM_DIGITS; d++) m_buf[d] = live_digit(m_mode, d);
                m_edit        = 1;
                m_cursor      = NUM_DIGITS - 1;
                m_edit_cycles = 0;
            end else if (mode_next) begin
                m_mode = (m_mode + 1) % NUM_MODES;
            end
        end
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic compareToModel();
        checkOutput("mode",         64'(bus.mode),         64'(m_mode));
        checkOutput("editing",      64'(bus.editing),      64'(m_edit));
        checkOutput("disp_data",    64'(bus.disp_data),    64'(e_disp));
        checkOutput("disp_char",    64'(bus.disp_char),    64'(e_char));
        checkOutput("disp_blank",   64'(bus.disp_blank),   64'(model_blank()));
        checkOutput("commit_valid", 64'(bus.commit_valid), 64'(e_valid));
        checkOutput("commit_mode",  64'(bus.commit_mode),  64'(e_cmode));
        checkOutput("commit_data",  64'(bus.commit_data),  64'(e_cdata));
    endtask

    task automatic applyStimulus(input bit mn, input bit sb, input bit nd, input bit ub);
        mode_next  = mn;
        set_btn    = sb;
        next_digit = nd;
        up_btn     = ub;
        @(posedge clk);
        model_edge();
        #1;
        mode_next  = 1'b0;
        set_btn    = 1'b0;
        next_digit = 1'b0;
        up_btn     = 1'b0;
        compareToModel();
        if (bus.commit_valid === 1'b1) commits++;
    endtask

    initial begin
        mode_next  = 1'b0;
        set_btn    = 1'b0;
        next_digit = 1'b0;
        up_btn     = 1'b0;
        src_data   = '0;
        src_char   = '0;
        model_reset();

        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        compareToModel();
        checkOutput("reset_disp", 64'(bus.disp_data), 64'd0);
        reset = 1'b0;

        for (int i = 0; i < NUM_MODES*NUM_DIGITS; i++) src_data[i*4 +: 4] = 4'($urandom_range(0, 15));
        src_data[(0*NUM_DIGITS + 6)*4 +: 4] = 4'd1;
        src_data[(0*NUM_DIGITS + 5)*4 +: 4] = 4'd2;
        src_data[(0*NUM_DIGITS + 4)*4 +: 4] = 4'd3;
        src_data[(0*NUM_DIGITS + 3)*4 +: 4] = 4'd4;
        src_data[(3*NUM_DIGITS + 6)*4 +: 4] = 4'd9;
        src_char = 4'b1000;
        applyStimulus(0, 0, 0, 0);

        // Mode walk 1, 2, 3, 0 with display following one cycle behind.
        for (int i = 0; i < NUM_MODES; i++) begin
            applyStimulus(1, 0, 0, 0);
            checkOutput("mode_walk", 64'(bus.mode), 64'((i + 1) % NUM_MODES));
            applyStimulus(0, 0, 0, 0);
        end

        // Edit session on mode 0: 1,2,3,4 -> 4,3,3,4.
        applyStimulus(0, 1, 0, 0);
        checkOutput("enter_editing", 64'(bus.editing), 64'd1);
        applyStimulus(0, 0, 0, 1);
        checkOutput("capture_disp", 64'(bus.disp_data), 64'h1234000);
        applyStimulus(0, 0, 0, 1);
        applyStimulus(0, 0, 0, 1);
        applyStimulus(0, 0, 1, 0);
        applyStimulus(0, 0, 0, 1);
        applyStimulus(0, 1, 0, 0);
        checkOutput("commit_early", 64'(bus.commit_valid), 64'd0);
        applyStimulus(0, 0, 0, 0);
        checkOutput("commit_valid", 64'(bus.commit_valid), 64'd1);
        checkOutput("commit_mode",  64'(bus.commit_mode),  64'd0);
        checkOutput("commit_4334",  64'(bus.commit_data),  64'h4334);
        applyStimulus(0, 0, 0, 0);
        checkOutput("commit_single", 64'(bus.commit_valid), 64'd0);
        checkOutput("commit_hold",   64'(bus.commit_data),  64'h4334);

        // Mode 1 is not editable.
        applyStimulus(1, 0, 0, 0);
        applyStimulus(0, 1, 0, 0);
        checkOutput("mode1_no_edit", 64'(bus.editing), 64'd0);
        repeat (3) applyStimulus(0, 0, 0, 0);

        // Mode 3 is a character mode: 9 increments to 10, then abort.
        applyStimulus(1, 0, 0, 0);
        applyStimulus(1, 0, 0, 0);
        checkOutput("mode3", 64'(bus.mode), 64'd3);
        applyStimulus(0, 1, 0, 0);
        applyStimulus(0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0);
        checkOutput("char_wrap", 64'(bus.disp_data[27:24]), 64'hA);
        applyStimulus(1, 0, 0, 0);
        checkOutput("abort_editing", 64'(bus.editing), 64'd0);
        checkOutput("abort_mode",    64'(bus.mode),    64'd3);
        for (int i = 0; i < 20; i++) begin
            applyStimulus(0, 0, 0, 0);
            checkOutput("abort_no_commit", 64'(bus.commit_valid), 64'd0);
        end

        // Cursor blink on mode 0, then moved one digit right.
        applyStimulus(1, 0, 0, 0);
        applyStimulus(0, 1, 0, 0);
        repeat (10) applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 0, 1, 0);
        repeat (10) applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 1, 0, 0);
        repeat (2) applyStimulus(0, 0, 0, 0);

        // Reset right after the commit-triggering set_btn.
        applyStimulus(0, 1, 0, 0);
        applyStimulus(0, 0, 0, 1);
        applyStimulus(0, 1, 0, 0);
        reset = 1'b1;
        #1;
        model_reset();
        compareToModel();
        @(posedge clk);
        #1;
        checkOutput("reset_no_commit", 64'(bus.commit_valid), 64'd0);
        compareToModel();
        reset = 1'b0;
        repeat (3) applyStimulus(0, 0, 0, 0);

        // Random button traffic with occasional source changes.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                int idx;
                idx = $urandom_range(0, NUM_MODES*NUM_DIGITS - 1);
                src_data[idx*4 +: 4] = 4'($urandom_range(0, 15));
            end
            if ($urandom_range(0, 63) == 0) src_char = 4'($urandom_range(0, 15));
            applyStimulus($urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0,
                          $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0);
        end
        $display("[TB] commit strobes observed: %0d", commits);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
